// File: rtl/theater_pkg.sv
// Shared constants for the theater input conditioner: debounce default,
// switch/sensor bit positions, reset levels and a small popcount helper.
package theater_pkg;

    localparam int DB_CYCLES_DEFAULT = 32'd16;

    localparam int PM_IDX = 32'd0;
    localparam int MM_IDX = 32'd1;
    localparam int SM_IDX = 32'd2;
    localparam int HM_IDX = 32'd3;

    localparam int TL_IDX = 32'd0;
    localparam int TC_IDX = 32'd1;
    localparam int TR_IDX = 32'd2;

    localparam logic SW_RST  = 1'b0;
    localparam logic SNS_RST = 1'b1;

    // Number of set bits in a 4-bit group; sensors pad their top bit with 0.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input path: two-flop synchronizer followed by a consecutive-cycle
// debouncer whose stable value only moves after DB_CYCLES agreeing samples.
module debounce_bit #(
    parameter int   DB_CYCLES = 32'd16,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DB_CYCLES + 32'd1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES - 32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    logic          meta_r;
    logic          sync_r;
    logic          db_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then count consecutive disagreeing samples before accepting them.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            db_r   <= RST_VAL;
            cnt_r  <= CNT_ZERO;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            if (sync_r == db_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_MAX) begin
                db_r  <= sync_r;
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign dout = db_r;

endmodule

// File: rtl/theater_input_conditioner.sv
// Debounces panel switches and active-low spotlight sensors, then enforces
// one-hot-or-none on each group. Define THEATER_FAULT_STICKY_EN to latch faults until reset.
module theater_input_conditioner
    import theater_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_sysen,
    input  logic raw_pm,
    input  logic raw_mm,
    input  logic raw_sm,
    input  logic raw_hm,
    input  logic raw_tl_n,
    input  logic raw_tc_n,
    input  logic raw_tr_n,
    output logic sys_en,
    output logic pm,
    output logic mm,
    output logic sm,
    output logic hm,
    output logic tl_n,
    output logic tc_n,
    output logic tr_n,
    output logic mode_fault,
    output logic sns_fault
);
    logic       db_sysen_s;
    logic [3:0] raw_mode_s;
    logic [3:0] db_mode_s;
    logic [2:0] raw_sns_n_s;
    logic [2:0] db_sns_n_s;
    logic [2:0] sns_act_s;

    logic [3:0] mode_nxt_s;
    logic [3:0] last_mode_nxt_s;
    logic       mode_conf_s;
    logic       mode_fault_nxt_s;
    logic [2:0] sns_act_nxt_s;
    logic [2:0] last_sns_nxt_s;
    logic       sns_conf_s;
    logic       sns_fault_nxt_s;

    logic       sys_en_r;
    logic [3:0] mode_r;
    logic [3:0] last_mode_r;
    logic [2:0] sns_n_r;
    logic [2:0] last_sns_r;
    logic       mode_fault_r;
    logic       sns_fault_r;

    assign raw_mode_s[PM_IDX]  = raw_pm;
    assign raw_mode_s[MM_IDX]  = raw_mm;
    assign raw_mode_s[SM_IDX]  = raw_sm;
    assign raw_mode_s[HM_IDX]  = raw_hm;
    assign raw_sns_n_s[TL_IDX] = raw_tl_n;
    assign raw_sns_n_s[TC_IDX] = raw_tc_n;
    assign raw_sns_n_s[TR_IDX] = raw_tr_n;

    debounce_bit #(.DB_CYCLES(DB_CYCLES), .RST_VAL(SW_RST)) u_db_sysen (
        .clk(clk), .rst(rst), .din(raw_sysen), .dout(db_sysen_s)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_mode
        debounce_bit #(.DB_CYCLES(DB_CYCLES), .RST_VAL(SW_RST)) u_db (
            .clk(clk), .rst(rst), .din(raw_mode_s[gi]), .dout(db_mode_s[gi])
        );
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_sns
        debounce_bit #(.DB_CYCLES(DB_CYCLES), .RST_VAL(SNS_RST)) u_db (
            .clk(clk), .rst(rst), .din(raw_sns_n_s[gi]), .dout(db_sns_n_s[gi])
        );
    end

    // Sensors are validated in active-high form so both groups share one rule.
    assign sns_act_s = ~db_sns_n_s;

    // Validate each group: none passes as all-off, one passes and is remembered, more holds the memory.
    always_comb begin
        mode_nxt_s      = 4'b0000;
        last_mode_nxt_s = last_mode_r;
        mode_conf_s     = 1'b0;
        case (popcount4(db_mode_s))
            3'd0: begin
                mode_nxt_s = 4'b0000;
            end
            3'd1: begin
                mode_nxt_s      = db_mode_s;
                last_mode_nxt_s = db_mode_s;
            end
            default: begin
                mode_nxt_s  = last_mode_r;
                mode_conf_s = 1'b1;
            end
        endcase

        sns_act_nxt_s  = 3'b000;
        last_sns_nxt_s = last_sns_r;
        sns_conf_s     = 1'b0;
        case (popcount4({1'b0, sns_act_s}))
            3'd0: begin
                sns_act_nxt_s = 3'b000;
            end
            3'd1: begin
                sns_act_nxt_s  = sns_act_s;
                last_sns_nxt_s = sns_act_s;
            end
            default: begin
                sns_act_nxt_s = last_sns_r;
                sns_conf_s    = 1'b1;
            end
        endcase

`ifdef THEATER_FAULT_STICKY_EN
        mode_fault_nxt_s = mode_fault_r | mode_conf_s;
        sns_fault_nxt_s  = sns_fault_r | sns_conf_s;
`else
        mode_fault_nxt_s = mode_conf_s;
        sns_fault_nxt_s  = sns_conf_s;
`endif
    end

    // Output, last-legal-pattern and fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sys_en_r     <= SW_RST;
            mode_r       <= 4'b0000;
            last_mode_r  <= 4'b0000;
            sns_n_r      <= 3'b111;
            last_sns_r   <= 3'b000;
            mode_fault_r <= 1'b0;
            sns_fault_r  <= 1'b0;
        end else begin
            sys_en_r     <= db_sysen_s;
            mode_r       <= mode_nxt_s;
            last_mode_r  <= last_mode_nxt_s;
            sns_n_r      <= ~sns_act_nxt_s;
            last_sns_r   <= last_sns_nxt_s;
            mode_fault_r <= mode_fault_nxt_s;
            sns_fault_r  <= sns_fault_nxt_s;
        end
    end

    assign sys_en     = sys_en_r;
    assign pm         = mode_r[PM_IDX];
    assign mm         = mode_r[MM_IDX];
    assign sm         = mode_r[SM_IDX];
    assign hm         = mode_r[HM_IDX];
    assign tl_n       = sns_n_r[TL_IDX];
    assign tc_n       = sns_n_r[TC_IDX];
    assign tr_n       = sns_n_r[TR_IDX];
    assign mode_fault = mode_fault_r;
    assign sns_fault  = sns_fault_r;

endmodule

// File: tb/tb_theater_input_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every registered
// output cycle; a monitor compares the DUT against the queued predictions.
module tb_theater_input_conditioner;
    localparam int DB = 4;
    // bit order: 0 sysen, 1 pm, 2 mm, 3 sm, 4 hm, 5 tl_n, 6 tc_n, 7 tr_n
    localparam logic [7:0] IDLE = 8'b1110_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_sysen, raw_pm, raw_mm, raw_sm, raw_hm, raw_tl_n, raw_tc_n, raw_tr_n;
    logic sys_en, pm, mm, sm, hm, tl_n, tc_n, tr_n, mode_fault, sns_fault;

    always #5 clk = ~clk;

    theater_input_conditioner #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst),
        .raw_sysen(raw_sysen), .raw_pm(raw_pm), .raw_mm(raw_mm), .raw_sm(raw_sm),
        .raw_hm(raw_hm), .raw_tl_n(raw_tl_n), .raw_tc_n(raw_tc_n), .raw_tr_n(raw_tr_n),
        .sys_en(sys_en), .pm(pm), .mm(mm), .sm(sm), .hm(hm),
        .tl_n(tl_n), .tc_n(tc_n), .tr_n(tr_n),
        .mode_fault(mode_fault), .sns_fault(sns_fault)
    );

    // Reference model state
    logic [7:0]  db_m;
    logic [15:0] hist_m [8];
    logic [3:0]  last_mode_m;
    logic [2:0]  last_sns_m;
    logic        mf_m, sf_m;
    logic [9:0]  exp_q [$];

    int checks = 0;
    int passed = 0;

    // Predict the outputs seen after the coming clock edge, given rst and raw at that edge.
    task automatic model_edge(input logic r, input logic [7:0] raw);
        logic [3:0] m, mo;
        logic [2:0] a, ao;
        logic       mc, sc, all_opp;
        if (r) begin
            db_m = IDLE;
            for (int i = 0; i < 8; i++) hist_m[i] = {16{IDLE[i]}};
            last_mode_m = 4'b0000;
            last_sns_m  = 3'b000;
            mf_m = 1'b0;
            sf_m = 1'b0;
            exp_q.push_back({2'b00, IDLE});
        end else begin
            m  = db_m[4:1];
            a  = ~db_m[7:5];
            mc = 1'b0;
            sc = 1'b0;
            if ($countones(m) == 0) mo = 4'b0000;
            else if ($countones(m) == 1) begin mo = m; last_mode_m = m; end
            else begin mo = last_mode_m; mc = 1'b1; end
            if ($countones(a) == 0) ao = 3'b000;
            else if ($countones(a) == 1) begin ao = a; last_sns_m = a; end
            else begin ao = last_sns_m; sc = 1'b1; end
`ifdef THEATER_FAULT_STICKY_EN
            mf_m = mf_m | mc;
            sf_m = sf_m | sc;
`else
            mf_m = mc;
            sf_m = sc;
`endif
            exp_q.push_back({sf_m, mf_m, ~ao, mo, db_m[0]});
            // Debounced value flips once the last DB synchronized samples all disagree with it.
            for (int i = 0; i < 8; i++) begin
                hist_m[i] = {hist_m[i][14:0], raw[i]};
                all_opp = 1'b1;
                for (int j = 2; j < DB + 2; j++)
                    if (hist_m[i][j] == db_m[i]) all_opp = 1'b0;
                if (all_opp) db_m[i] = ~db_m[i];
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] raw);
        @(negedge clk);
        rst = r;
        {raw_tr_n, raw_tc_n, raw_tl_n, raw_hm, raw_sm, raw_mm, raw_pm, raw_sysen} = raw;
        model_edge(r, raw);
    endtask

    // Monitor: compare each cycle's outputs against the oldest prediction.
    always @(posedge clk) begin
        logic [9:0] e, act;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {sns_fault, mode_fault, tr_n, tc_n, tl_n, hm, sm, mm, pm, sys_en};
            checks++;
            if (act === e) passed++;
            else $display("FAIL outputs t=%0t got=%b expected=%b", $time, act, e);
        end
    end

    initial begin
        logic [7:0] cur;
        // reset then idle
        repeat (3) step(1'b1, IDLE);
        repeat (8) step(1'b0, IDLE);
        // MUSIC held, then released
        cur = IDLE | 8'h04;
        repeat (12) step(1'b0, cur);
        repeat (10) step(1'b0, IDLE);
        // three-cycle PLAY glitch
        repeat (3) step(1'b0, IDLE | 8'h02);
        repeat (10) step(1'b0, IDLE);
        // PLAY held, SPEAKER joins, PLAY released
        repeat (10) step(1'b0, IDLE | 8'h02);
        repeat (12) step(1'b0, IDLE | 8'h0A);
        repeat (12) step(1'b0, IDLE | 8'h08);
        repeat (10) step(1'b0, IDLE);
        // left sensor, then right sensor too, then release
        repeat (10) step(1'b0, IDLE & 8'hDF);
        repeat (10) step(1'b0, IDLE & 8'h5F);
        repeat (10) step(1'b0, IDLE);
        // reset in the middle of a HOUSE debounce
        cur = IDLE | 8'h10;
        repeat (4) step(1'b0, cur);
        step(1'b1, cur);
        repeat (12) step(1'b0, cur);
        // randomized section with occasional resets
        cur = IDLE;
        repeat (3000) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 9) == 0) cur[i] = ~cur[i];
            step($urandom_range(0, 299) == 0, cur);
        end
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain pending=%0d expected=0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
